pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage RV32 pipeline (IF, ID, EX, MA, WB). It combines four hazard sources: load-use, multi-cycle MUL/DIV occupancy of EX, data-memory wait, and a taken branch/jump redirect from EX. It drives per-stage pipeline-register enables and flushes, and keeps a stall-cycle performance counter. Targets are the PC, IFID, IDEX, EXMA and MAWB registers.

Parameters:
MUL_LAT, 3, EX occupancy in cycles of a multiply (>=1)
DIV_LAT, 32, EX occupancy in cycles of a divide/remainder (>=1)
CNT_W, 6, occupancy counter width; must hold max(MUL_LAT,DIV_LAT)-1

Ports:
clk  in  1  clock; all state updates on rising edge
rstn  in  1  synchronous reset, active-low
IFIDrs1In  in  5  rs1 of instruction in ID
IFIDrs2In  in  5  rs2 of instruction in ID
IFIDUsesRs1In  in  1  ID instruction reads rs1
IFIDUsesRs2In  in  1  ID instruction reads rs2
IDEXMemReadIn  in  1  EX instruction is a load
IDEXrdIn  in  5  rd of EX instruction
IDEXMdStartIn  in  1  EX holds a valid MUL/DIV instruction
IDEXMdIsDivIn  in  1  1 = divide class, 0 = multiply class
EXBranchTakenIn  in  1  EX resolves a taken branch/jump
MemReqIn  in  1  MA stage issues a data-memory access
MemAckIn  in  1  data memory completes the access this cycle
pcEnOut  out  1  PC update enable
ifidEnOut  out  1  IFID load enable
idexEnOut  out  1  IDEX load enable
exmaEnOut  out  1  EXMA load enable
mawbEnOut  out  1  MAWB load enable
ifidFlushOut  out  1  load NOP into IFID
idexFlushOut  out  1  load NOP into IDEX
exmaBubbleOut  out  1  load NOP into EXMA
mdBusyOut  out  1  state == MD_BUSY
stateOut  out  2  0 RUN, 1 MD_BUSY, 2 MEM_WAIT
stallCntOut  out  32  cycles with pcEnOut==0, saturating

Behaviour:
- Outputs are combinational from the registered state, counter and current inputs. The state, counter and stallCntOut are registered.
- Reset (rstn=0 at an edge): state=RUN, cnt=0, stallCntOut=0. While rstn=0, outputs are forced: all *En=1, all flush/bubble=0, mdBusyOut=0. Reset mid-MD_BUSY or mid-MEM_WAIT abandons the operation.
- Default outputs: all *En=1, flush/bubble=0.
- RUN rule chain, first match wins:
  1. memWait = MemReqIn & ~MemAckIn. All five *En=0. Next state MEM_WAIT.
  2. IDEXMdStartIn with lat>1, where lat = IDEXMdIsDivIn ? DIV_LAT : MUL_LAT. Set pcEn/ifidEn/idexEn=0, exmaBubble=1, mawbEn=1. Load cnt=lat-1. Next state MD_BUSY. If lat==1, no action.
  3. EXBranchTakenIn. Set ifidFlush=1, idexFlush=1, all *En=1. Stay RUN.
  4. Load-use: IDEXMemReadIn & IDEXrdIn!=0 & ((IFIDUsesRs1In & rs1==rd) | (IFIDUsesRs2In & rs2==rd)). Set pcEn=0, ifidEn=0, idexFlush=1. Stay RUN. Lasts exactly 1 cycle per hazard.
- MD_BUSY:
  - If memWait: all *En=0; cnt holds; stay MD_BUSY.
  - Else if cnt>1: pcEn/ifidEn/idexEn=0, exmaBubble=1, mawbEn=1; cnt decrements.
  - Else (cnt==1), the release cycle: apply RUN rules 3–4 (the EX result is captured into EXMA). cnt becomes 0. Next state RUN.
  - Total EX occupancy of one MUL/DIV is exactly lat cycles when there is no memory wait.
- MEM_WAIT:
  - If MemAckIn=0: all *En=0; stay.
  - If MemAckIn=1: evaluate the full RUN rule chain with memWait treated as false. Next state comes from that evaluation (RUN or MD_BUSY).
- Simultaneous events: branch and load-use are mutually exclusive in practice (EX holds one instruction); branch priority is fixed regardless. A flush always coexists with enables held at 1.
- stallCntOut increments on each cycle with rstn=1 and pcEnOut=0. It saturates at 32'hFFFF_FFFF and never wraps.
- rd==x0 never causes a load-use stall.

Test Plan:
- Load-use: IDEXMemRead=1, rd=5, rs1=5, UsesRs1=1 -> exactly 1 cycle with pcEn=0, ifidEn=0, idexFlush=1; stallCnt+1. Repeat with rd=0 -> no stall.
- Divide, DIV_LAT=4: MdStart=1, IsDiv=1 at cycle 0 -> pcEn=0 and exmaBubble=1 in cycles 0–3… specifically cycles 0–2; cycle 3 all En=1; mdBusy=1 in cycles 1–3; stateOut returns to 0 at cycle 4; stallCnt=3.
- Memory wait: MemReq=1, Ack=0 for 3 cycles then 1 -> all En=0 for 3 cycles, stateOut=2 during the wait, all En=1 on the ack cycle, stallCnt=3.
- Branch: EXBranchTaken=1 for 1 cycle -> ifidFlush=idexFlush=1, all En=1, no stallCnt change.
- MUL_LAT=3 with MemReq=1/Ack=0 for 2 cycles in the first MD_BUSY cycle -> cnt frozen, all En=0; release occurs 2 cycles later than the unstalled case.
- rstn=0 during MD_BUSY -> next cycle stateOut=0, stallCntOut=0, all En=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard control bundle: hazard sources in, stage enables/flushes and status out.
// The master side drives hazard sources; the slave side is the scheduler.
interface pipe_hazard_ctrl_if;
  logic [4:0]  IFIDrs1In;
  logic [4:0]  IFIDrs2In;
  logic        IFIDUsesRs1In;
  logic        IFIDUsesRs2In;
  logic        IDEXMemReadIn;
  logic [4:0]  IDEXrdIn;
  logic        IDEXMdStartIn;
  logic        IDEXMdIsDivIn;
  logic        EXBranchTakenIn;
  logic        MemReqIn;
  logic        MemAckIn;
  logic        pcEnOut;
  logic        ifidEnOut;
  logic        idexEnOut;
  logic        exmaEnOut;
  logic        mawbEnOut;
  logic        ifidFlushOut;
  logic        idexFlushOut;
  logic        exmaBubbleOut;
  logic        mdBusyOut;
  logic [1:0]  stateOut;
  logic [31:0] stallCntOut;

  modport master (
    output IFIDrs1In, IFIDrs2In, IFIDUsesRs1In, IFIDUsesRs2In, IDEXMemReadIn,
           IDEXrdIn, IDEXMdStartIn, IDEXMdIsDivIn, EXBranchTakenIn, MemReqIn, MemAckIn,
    input  pcEnOut, ifidEnOut, idexEnOut, exmaEnOut, mawbEnOut, ifidFlushOut,
           idexFlushOut, exmaBubbleOut, mdBusyOut, stateOut, stallCntOut
  );

  modport slave (
    input  IFIDrs1In, IFIDrs2In, IFIDUsesRs1In, IFIDUsesRs2In, IDEXMemReadIn,
           IDEXrdIn, IDEXMdStartIn, IDEXMdIsDivIn, EXBranchTakenIn, MemReqIn, MemAckIn,
    output pcEnOut, ifidEnOut, idexEnOut, exmaEnOut, mawbEnOut, ifidFlushOut,
           idexFlushOut, exmaBubbleOut, mdBusyOut, stateOut, stallCntOut
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for a 5-stage RV32 pipeline: load-use, MUL/DIV occupancy,
// data-memory wait and branch redirect, plus a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input logic              clk,
  input logic              rstn,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MUL_M1 = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV_LAT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      stall_cnt;

  logic pc_en, ifid_en, idex_en, exma_en, mawb_en;
  logic ifid_flush, idex_flush, exma_bubble;
  logic mem_wait, load_use, do_run, do_tail;
  logic [CNT_W-1:0] lat_m1;

  assign mem_wait = bus.MemReqIn & ~bus.MemAckIn;
  assign lat_m1   = bus.IDEXMdIsDivIn ? DIV_M1 : MUL_M1;
  assign load_use = bus.IDEXMemReadIn && (bus.IDEXrdIn != 5'd0) &&
                    ((bus.IFIDUsesRs1In && (bus.IFIDrs1In == bus.IDEXrdIn)) ||
                     (bus.IFIDUsesRs2In && (bus.IFIDrs2In == bus.IDEXrdIn)));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= RUN;
      cnt       <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!bus.pcEnOut && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exma_en     = 1'b1;
    mawb_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exma_bubble = 1'b0;
    do_run      = 1'b0;
    do_tail     = 1'b0;

    unique case (state)
      RUN: do_run = 1'b1;
      MD_BUSY: begin
        if (mem_wait) begin
          {pc_en, ifid_en, idex_en, exma_en, mawb_en} = '0;
        end else if (cnt > CNT_W'(1)) begin
          {pc_en, ifid_en, idex_en} = '0;
          exma_bubble = 1'b1;
          cnt_nxt     = cnt - CNT_W'(1);
        end else begin
          // Release cycle: the MUL/DIV result moves into EXMA.
          do_tail   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      MEM_WAIT: begin
        if (!bus.MemAckIn) {pc_en, ifid_en, idex_en, exma_en, mawb_en} = '0;
        else do_run = 1'b1;
      end
      default: state_nxt = RUN;
    endcase

    if (do_run) begin
      if (mem_wait) begin
        {pc_en, ifid_en, idex_en, exma_en, mawb_en} = '0;
        state_nxt = MEM_WAIT;
      end else if (bus.IDEXMdStartIn && (lat_m1 != '0)) begin
        {pc_en, ifid_en, idex_en} = '0;
        exma_bubble = 1'b1;
        cnt_nxt     = lat_m1;
        state_nxt   = MD_BUSY;
      end else begin
        do_tail   = 1'b1;
        state_nxt = RUN;
      end
    end

    if (do_tail) begin
      if (bus.EXBranchTakenIn) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  // Outputs are forced to the pass-through pattern while reset is held.
  assign bus.pcEnOut       = rstn ? pc_en       : 1'b1;
  assign bus.ifidEnOut     = rstn ? ifid_en     : 1'b1;
  assign bus.idexEnOut     = rstn ? idex_en     : 1'b1;
  assign bus.exmaEnOut     = rstn ? exma_en     : 1'b1;
  assign bus.mawbEnOut     = rstn ? mawb_en     : 1'b1;
  assign bus.ifidFlushOut  = rstn & ifid_flush;
  assign bus.idexFlushOut  = rstn & idex_flush;
  assign bus.exmaBubbleOut = rstn & exma_bubble;
  assign bus.mdBusyOut     = rstn & (state == MD_BUSY);
  assign bus.stateOut      = state;
  assign bus.stallCntOut   = stall_cnt;

endmodule
